// File: rtl/uart_tx_key_arbiter_pkg.sv
// Shared types and constants for the UART key arbiter.
package uart_tx_key_arbiter_pkg;

   localparam int unsigned REQ_COUNT = 4;
   localparam int unsigned PTR_WIDTH = 2;

   // ASCII byte sent for each key
   localparam logic [7:0] KEY_A_BYTE = 8'h61;
   localparam logic [7:0] KEY_S_BYTE = 8'h73;
   localparam logic [7:0] KEY_D_BYTE = 8'h64;
   localparam logic [7:0] KEY_W_BYTE = 8'h77;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } arb_state_e;

   // Arbiter result: whether anything won, which line, and its index
   typedef struct packed {
      logic                 valid;
      logic [REQ_COUNT-1:0] onehot;
      logic [PTR_WIDTH-1:0] idx;
   } rr_grant_t;

   // Map a requester index (a,s,d,w order) to its ASCII byte
   function automatic logic [7:0] key_byte(input logic [PTR_WIDTH-1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = KEY_A_BYTE;
         2'd1:    b = KEY_S_BYTE;
         2'd2:    b = KEY_D_BYTE;
         default: b = KEY_W_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_key_arbiter_rr_arbiter4.sv
// Four-way combinational round-robin picker: first pending line at or after
// the pointer, scanning a,s,d,w and wrapping from w back to a.
module rr_arbiter4
   import uart_tx_key_arbiter_pkg::*;
(
   input  logic [REQ_COUNT-1:0] pending_i,
   input  logic [PTR_WIDTH-1:0] ptr_i,
   output rr_grant_t            grant_o
);

   logic [PTR_WIDTH-1:0] scan_idx;

   // Scan from the pointer; the first hit wins
   always_comb begin
      grant_o  = '0;
      scan_idx = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         scan_idx = ptr_i + PTR_WIDTH'(k);
         if (!grant_o.valid && pending_i[scan_idx]) begin
            grant_o.valid  = 1'b1;
            grant_o.onehot = REQ_COUNT'(1) << scan_idx;
            grant_o.idx    = scan_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_key_arbiter.sv
// Shares one UART transmitter among keys a,s,d,w: latches press edges as
// pending requests, grants round-robin, pulses start with the key's byte and
// waits for the frame to finish (or for the ack timeout) before re-arbitrating.
// Optional feature: define UART_ARB_REPEAT_EN to auto-repeat held keys every
// REPEAT_CLOCKS cycles.
module uart_tx_key_arbiter
   import uart_tx_key_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned ACK_TIMEOUT   = 1023,
   parameter int unsigned TIMEOUT_WIDTH = 10,
   parameter int unsigned REPEAT_CLOCKS = 5000000,
   parameter int unsigned REPEAT_WIDTH  = 23
)(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_key_a,
   input  logic                  i_key_s,
   input  logic                  i_key_d,
   input  logic                  i_key_w,
   input  logic                  i_tx_busy,
   output logic                  o_tx_start,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic [NUM_REQ-1:0]    o_pending,
   output logic [NUM_REQ-1:0]    o_grant
);

   arb_state_e                state_q,  state_d;
   logic [NUM_REQ-1:0]        key_q;
   logic [NUM_REQ-1:0]        pend_q,   pend_d;
   logic [PTR_WIDTH-1:0]      ptr_q,    ptr_d;
   logic                      start_q,  start_d;
   logic [DATA_WIDTH-1:0]     data_q,   data_d;
   logic [NUM_REQ-1:0]        grant_q,  grant_d;
   logic [TIMEOUT_WIDTH-1:0]  tmo_q,    tmo_d;

   logic [NUM_REQ-1:0]        key_vec_c;
   logic [NUM_REQ-1:0]        rise_c;
   logic [NUM_REQ-1:0]        rpt_set_c;
   logic [NUM_REQ-1:0]        clr_c;
   rr_grant_t                 arb_c;

   assign key_vec_c = {i_key_w, i_key_d, i_key_s, i_key_a};
   assign rise_c    = key_vec_c & ~key_q;

   rr_arbiter4 u_rr (
      .pending_i (pend_q),
      .ptr_i     (ptr_q),
      .grant_o   (arb_c)
   );

`ifdef UART_ARB_REPEAT_EN
   logic [REPEAT_WIDTH-1:0] rpt_q [NUM_REQ];
   logic [REPEAT_WIDTH-1:0] rpt_d [NUM_REQ];

   // Per-key hold counter: zero on press or release, re-request on wrap
   always_comb begin
      rpt_set_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rpt_d[i] = '0;
         if (key_vec_c[i] && key_q[i]) begin
            if (rpt_q[i] == REPEAT_WIDTH'(REPEAT_CLOCKS - 1)) begin
               rpt_set_c[i] = 1'b1;
            end else begin
               rpt_d[i] = rpt_q[i] + REPEAT_WIDTH'(1);
            end
         end
      end
   end

   // Hold counter registers
   always_ff @(posedge i_clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_reset) begin
            rpt_q[i] <= '0;
         end else begin
            rpt_q[i] <= rpt_d[i];
         end
      end
   end
`else
   logic unused_repeat_cfg;
   assign rpt_set_c         = '0;
   assign unused_repeat_cfg = ^{REPEAT_CLOCKS, REPEAT_WIDTH};
`endif

   // Next-state, grant and pending update; a new press beats a same-cycle clear
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      data_d  = data_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      tmo_d   = tmo_q;
      clr_c   = '0;

      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (arb_c.valid && !i_tx_busy) begin
               state_d = ST_START;
               start_d = 1'b1;
               data_d  = DATA_WIDTH'(key_byte(arb_c.idx));
               grant_d = arb_c.onehot;
               clr_c   = arb_c.onehot;
               ptr_d   = arb_c.idx + PTR_WIDTH'(1);
            end
         end
         ST_START: begin
            state_d = ST_WAIT_ACK;
            tmo_d   = '0;
         end
         ST_WAIT_ACK: begin
            if (i_tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_q == TIMEOUT_WIDTH'(ACK_TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else begin
               tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!i_tx_busy) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      pend_d = (pend_q & ~clr_c) | rise_c | rpt_set_c;
   end

   // State, request and output registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         pend_q  <= '0;
         ptr_q   <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         grant_q <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_vec_c;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         start_q <= start_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         tmo_q   <= tmo_d;
      end
   end

   assign o_tx_start = start_q;
   assign o_tx_data  = data_q;
   assign o_pending  = pend_q;
   assign o_grant    = grant_q;

endmodule

// File: tb/tb_uart_tx_key_arbiter.sv
// Bench for uart_tx_key_arbiter: transaction-level model of the shared
// transmitter, a per-cycle compare, and literal checks on the start sequence.
// Honours UART_ARB_REPEAT_EN the same way as the design.
module tb_uart_tx_key_arbiter;

   localparam int ACK_T = 1023;
   localparam int REP   = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] keys = 4'b0;   // {w,d,s,a}
   logic       tx_busy = 1'b0;
   logic       dut_start;
   logic [7:0] dut_data;
   logic [3:0] dut_pend;
   logic [3:0] dut_grant;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   uart_tx_key_arbiter #(.REPEAT_CLOCKS(REP)) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_key_a    (keys[0]),
      .i_key_s    (keys[1]),
      .i_key_d    (keys[2]),
      .i_key_w    (keys[3]),
      .i_tx_busy  (tx_busy),
      .o_tx_start (dut_start),
      .o_tx_data  (dut_data),
      .o_pending  (dut_pend),
      .o_grant    (dut_grant)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter stand-in: busy for 20 cycles starting the cycle after start
   bit busy_en   = 1'b1;
   bit hold_busy = 1'b0;
   bit saw_start = 1'b0;
   int busy_left = 0;
   bit frame_on;
   always begin
      @(negedge clk);
      saw_start = dut_start;
      @(posedge clk);
      #1;
      if (saw_start && busy_en) busy_left = 20;
      frame_on = (busy_left > 0);
      if (frame_on) busy_left--;
      tx_busy = frame_on | hold_busy;
   end

   // Model: channel is free, pulsing, awaiting ack, or carrying a frame
   logic [7:0] kbytes [4] = '{8'h61, 8'h73, 8'h64, 8'h77};
   logic [3:0] m_pend = '0, m_prev = '0, m_grant = '0, new_req;
   logic [7:0] m_data = '0;
   int  m_ptr = 0, m_ack_cnt = 0, g;
   bit  m_pulse = 0, m_wait_ack = 0, m_in_frame = 0;
   int  m_held [4] = '{0, 0, 0, 0};
   always @(posedge clk) begin
      if (rst) begin
         m_pend = '0; m_grant = '0; m_data = '0; m_ptr = 0;
         m_pulse = 0; m_wait_ack = 0; m_in_frame = 0; m_ack_cnt = 0;
         for (int i = 0; i < 4; i++) m_held[i] = 0;
         m_prev = '0;
      end else begin
         new_req = keys & ~m_prev;
`ifdef UART_ARB_REPEAT_EN
         for (int i = 0; i < 4; i++) begin
            if (keys[i] && m_prev[i]) begin
               m_held[i]++;
               if (m_held[i] % REP == 0) new_req[i] = 1'b1;
            end else begin
               m_held[i] = 0;
            end
         end
`endif
         if (m_pulse) begin
            m_pulse = 0; m_wait_ack = 1; m_ack_cnt = 0;
         end else if (m_wait_ack) begin
            if (tx_busy) begin
               m_wait_ack = 0; m_in_frame = 1;
            end else begin
               m_ack_cnt++;
               if (m_ack_cnt == ACK_T) begin m_wait_ack = 0; m_grant = '0; end
            end
         end else if (m_in_frame) begin
            if (!tx_busy) begin m_in_frame = 0; m_grant = '0; end
         end else if (m_pend != 0 && !tx_busy) begin
            g = -1;
            for (int k = 0; k < 4; k++)
               if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            m_pulse = 1;
            m_data  = kbytes[g];
            m_grant = 4'(1 << g);
            m_pend[g] = 1'b0;
            m_ptr   = (g + 1) % 4;
         end
         m_pend = m_pend | new_req;
         m_prev = keys;
      end
   end

   // Per-cycle compare against the model; also log every start
   logic [7:0] sq [$];
   int         st [$];
   always @(negedge clk) begin
      n_vec++;
      if ({dut_start, dut_data, dut_pend, dut_grant} !== {m_pulse, m_data, m_pend, m_grant}) begin
         n_err++;
         $display("FAIL cycle %0d outputs: got start=%b data=%h pend=%b grant=%b, required start=%b data=%h pend=%b grant=%b",
                  cyc, dut_start, dut_data, dut_pend, dut_grant, m_pulse, m_data, m_pend, m_grant);
      end
      if (dut_start === 1'b1) begin
         sq.push_back(dut_data);
         st.push_back(cyc);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] mask, input int hold, output int t);
      @(posedge clk); #1;
      keys = mask;
      t = cyc;
      repeat (hold) @(posedge clk);
      #1;
      keys = 4'b0;
   endtask

   task automatic clear_log();
      sq.delete();
      st.delete();
   endtask

   logic [7:0] exp4 [4] = '{8'h61, 8'h73, 8'h64, 8'h77};
   int t0, t1;
   int n_frames;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      cycles(3);
      @(negedge clk);
      check("reset start", int'(dut_start), 0);
      check("reset data",  int'(dut_data),  0);
      check("reset grant", int'(dut_grant), 0);
      @(posedge clk); #1 rst = 1'b0;
      cycles(2);

      // All four keys at once, from pointer a
      clear_log();
      press(4'b1111, 1, t0);
      cycles(120);
      check("burst count", sq.size(), 4);
      for (int i = 0; i < 4 && i < sq.size(); i++) check($sformatf("burst byte %0d", i), int'(sq[i]), int'(exp4[i]));

      // a+w after pointer wrapped back to a
      clear_log();
      press(4'b1001, 1, t0);
      cycles(60);
      check("aw count", sq.size(), 2);
      if (sq.size() == 2) begin
         check("aw first", int'(sq[0]), 'h61);
         check("aw second", int'(sq[1]), 'h77);
      end

      // Single s pulse, two-cycle press-to-start latency
      clear_log();
      press(4'b0010, 1, t0);
      cycles(40);
      check("s count", sq.size(), 1);
      if (sq.size() == 1) begin
         check("s byte", int'(sq[0]), 'h73);
         check("s latency", st[0] - t0, 2);
      end
      check("s grant idle", int'(dut_grant), 0);

      // Reset in the middle of a frame with s,d pending
      press(4'b0001, 1, t0);
      cycles(8);
      press(4'b0110, 1, t0);
      cycles(2);
      @(negedge clk);
      check("pre-reset pending", int'(dut_pend), 'b0110);
      check("pre-reset grant", int'(dut_grant), 'b0001);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid reset pending", int'(dut_pend), 0);
      check("mid reset grant", int'(dut_grant), 0);
      check("mid reset data", int'(dut_data), 0);
      @(posedge clk); #1 rst = 1'b0;
      cycles(30);

      // d re-pressed during its own frame
      clear_log();
      press(4'b0100, 1, t0);
      cycles(6);
      press(4'b0100, 1, t0);
      cycles(60);
      check("d repress count", sq.size(), 2);
      if (sq.size() == 2) check("d repress byte", int'(sq[1]), 'h64);

      // Busy never rises: give up after the ack timeout, then serve s
      busy_en = 1'b0;
      clear_log();
      press(4'b0001, 1, t0);
      cycles(5);
      press(4'b0010, 1, t1);
      cycles(2100);
      busy_en = 1'b1;
      check("timeout count", sq.size(), 2);
      if (sq.size() == 2) begin
         check("timeout second byte", int'(sq[1]), 'h73);
         check("timeout gap", st[1] - st[0], ACK_T + 2);
      end

      // Busy high while idle holds off the start
      hold_busy = 1'b1;
      clear_log();
      press(4'b1000, 1, t0);
      cycles(10);
      check("busy idle no start", sq.size(), 0);
      hold_busy = 1'b0;
      cycles(30);
      check("busy idle late start", sq.size(), 1);
      if (sq.size() == 1) check("busy idle byte", int'(sq[0]), 'h77);

      // w held for 350 cycles
      clear_log();
      press(4'b1000, 350, t0);
      cycles(60);
`ifdef UART_ARB_REPEAT_EN
      n_frames = 4;
`else
      n_frames = 1;
`endif
      check("hold w frames", sq.size(), n_frames);
      for (int i = 0; i < sq.size(); i++) check($sformatf("hold w byte %0d", i), int'(sq[i]), 'h77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
